flash_seq: RTL and testbench

Command sequencer that drives the byte-strobe side of the flash programmer's ROM controller. It turns single host commands (read byte, program byte, sector erase, chip erase) into the JEDEC bus-cycle sequences the ROM controller executes. Each sequence is a run of address-load and data strobes. After program and erase it runs DQ7 data polling. It sits between the host command decoder and the ROM controller, and reports completion or failure back to the host.

---
 rtl/flash_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_flash_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/flash_seq.sv
// rtl/flash_seq.sv - JEDEC command sequencer for the ROM controller byte-strobe port
// Expands host commands into address/data bus cycles and runs DQ7/DQ5 data polling.
module flash_seq #(
  parameter int unsigned ACC_GAP  = 8,
  parameter logic [25:0] POLL_MAX = 26'h3FF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rd,
  input  logic        cmd_prog,
  input  logic        cmd_serase,
  input  logic        cmd_cerase,
  input  logic [18:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        wr_addr,
  output logic        wr_data,
  output logic        rd_data,
  output logic [7:0]  wr_buffer,
  input  logic [7:0]  rd_buffer
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_ADDR2, S_ACCESS, S_GAP, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {C_RD, C_PROG, C_SER, C_CER} cmd_e;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
    logic        rd;
  } bc_t;

  localparam int unsigned    GW       = $clog2(ACC_GAP);
  localparam logic [GW-1:0]  GAP_LAST = GW'(ACC_GAP - 1);
  localparam logic [18:0]    UNLOCK1  = 19'h00555;
  localparam logic [18:0]    UNLOCK2  = 19'h002AA;

  // Bus cycle for a given sequence step; steps past the last write are poll reads.
  function automatic bc_t seq_bc(input cmd_e c, input logic [2:0] st,
                                 input logic [18:0] a, input logic [7:0] d);
    bc_t b;
    b = '{addr: a, data: 8'h00, rd: 1'b1};
    if (c == C_PROG) begin
      case (st)
        3'd0:    b = '{UNLOCK1, 8'hAA, 1'b0};
        3'd1:    b = '{UNLOCK2, 8'h55, 1'b0};
        3'd2:    b = '{UNLOCK1, 8'hA0, 1'b0};
        3'd3:    b = '{a, d, 1'b0};
        default: b = '{a, 8'h00, 1'b1};
      endcase
    end else if (c == C_SER || c == C_CER) begin
      case (st)
        3'd0: b = '{UNLOCK1, 8'hAA, 1'b0};
        3'd1: b = '{UNLOCK2, 8'h55, 1'b0};
        3'd2: b = '{UNLOCK1, 8'h80, 1'b0};
        3'd3: b = '{UNLOCK1, 8'hAA, 1'b0};
        3'd4: b = '{UNLOCK2, 8'h55, 1'b0};
        3'd5: begin
          if (c == C_SER) b = '{a, 8'h30, 1'b0};
          else            b = '{UNLOCK1, 8'h10, 1'b0};
        end
        default: begin
          if (c == C_CER) b.addr = 19'h0;
        end
      endcase
    end
    return b;
  endfunction

  state_e      state_q;
  cmd_e        cmd_q;
  logic [2:0]  step_q;
  logic [18:0] addr_q;
  logic [7:0]  data_q;
  logic [18:0] bc_addr_q;
  logic [7:0]  bc_data_q;
  logic        bc_rd_q;
  logic        rechk_q;
  logic [GW-1:0] gap_q;
  logic [25:0] poll_cnt_q;
  logic        busy_q, done_q, err_q;
  logic [7:0]  rdata_q;
  logic        wr_addr_q, wr_data_q, rd_data_q;
  logic [7:0]  wr_buffer_q;

  logic any_cmd_d;
  cmd_e new_cmd_d;
  bc_t  start_bc_d;
  bc_t  next_bc_d;
  logic poll_ok_d;

  always_comb begin
    any_cmd_d = cmd_rd | cmd_prog | cmd_serase | cmd_cerase;
    new_cmd_d = C_CER;
    if (cmd_rd)          new_cmd_d = C_RD;
    else if (cmd_prog)   new_cmd_d = C_PROG;
    else if (cmd_serase) new_cmd_d = C_SER;
    start_bc_d = seq_bc(new_cmd_d, 3'd0, cmd_addr, cmd_data);
    next_bc_d  = seq_bc(cmd_q, step_q + 3'd1, addr_q, data_q);
    poll_ok_d  = (rd_buffer[7] == ((cmd_q == C_PROG) ? data_q[7] : 1'b1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= C_RD;
      step_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      bc_addr_q   <= '0;
      bc_data_q   <= '0;
      bc_rd_q     <= 1'b0;
      rechk_q     <= 1'b0;
      gap_q       <= '0;
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      wr_addr_q   <= 1'b0;
      wr_data_q   <= 1'b0;
      rd_data_q   <= 1'b0;
      wr_buffer_q <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= 1'b0;
      wr_data_q <= 1'b0;
      rd_data_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_cmd_d) begin
            cmd_q       <= new_cmd_d;
            addr_q      <= cmd_addr;
            data_q      <= cmd_data;
            step_q      <= '0;
            poll_cnt_q  <= '0;
            rechk_q     <= 1'b0;
            busy_q      <= 1'b1;
            bc_addr_q   <= start_bc_d.addr;
            bc_data_q   <= start_bc_d.data;
            bc_rd_q     <= start_bc_d.rd;
            state_q     <= S_ADDR0;
            wr_addr_q   <= 1'b1;
            wr_buffer_q <= start_bc_d.addr[7:0];
          end
        end
        S_ADDR0: begin
          state_q     <= S_ADDR1;
          wr_addr_q   <= 1'b1;
          wr_buffer_q <= bc_addr_q[15:8];
        end
        S_ADDR1: begin
          state_q     <= S_ADDR2;
          wr_addr_q   <= 1'b1;
          wr_buffer_q <= {5'b0, bc_addr_q[18:16]};
        end
        S_ADDR2: begin
          state_q <= S_ACCESS;
          if (bc_rd_q) begin
            rd_data_q <= 1'b1;
          end else begin
            wr_data_q   <= 1'b1;
            wr_buffer_q <= bc_data_q;
          end
        end
        S_ACCESS: begin
          state_q <= S_GAP;
          gap_q   <= '0;
        end
        S_GAP: begin
          if (gap_q != GAP_LAST) begin
            gap_q <= gap_q + GW'(1);
          end else if (!bc_rd_q) begin
            step_q      <= step_q + 3'd1;
            bc_addr_q   <= next_bc_d.addr;
            bc_data_q   <= next_bc_d.data;
            bc_rd_q     <= next_bc_d.rd;
            state_q     <= S_ADDR0;
            wr_addr_q   <= 1'b1;
            wr_buffer_q <= next_bc_d.addr[7:0];
          end else begin
            // Last gap cycle of a read: the controller's byte is valid now.
            rdata_q <= rd_buffer;
            if (cmd_q == C_RD || poll_ok_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (rechk_q || (poll_cnt_q == POLL_MAX - 26'd1 && !rd_buffer[5])) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              if (rd_buffer[5]) rechk_q    <= 1'b1;
              else              poll_cnt_q <= poll_cnt_q + 26'd1;
              state_q     <= S_ADDR0;
              wr_addr_q   <= 1'b1;
              wr_buffer_q <= bc_addr_q[7:0];
            end
          end
        end
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_data   = rd_data_q;
  assign wr_buffer = wr_buffer_q;

endmodule

// File: tb/tb_flash_seq.sv
// tb/tb_flash_seq.sv - table-driven bench for flash_seq
// Records every bus cycle the sequencer issues and checks it against hand-written vectors.
module tb_flash_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_rd = 1'b0, cmd_prog = 1'b0, cmd_serase = 1'b0, cmd_cerase = 1'b0;
  logic [18:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        busy, done, err, wr_addr, wr_data, rd_data;
  logic [7:0]  rdata, wr_buffer;
  logic [7:0]  rd_buffer = 8'h00;

  int n_chk  = 0;
  int n_fail = 0;

  flash_seq #(.ACC_GAP(8), .POLL_MAX(26'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_rd(cmd_rd), .cmd_prog(cmd_prog), .cmd_serase(cmd_serase), .cmd_cerase(cmd_cerase),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data),
    .wr_buffer(wr_buffer), .rd_buffer(rd_buffer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]           cmds;     // {rd, prog, serase, cerase}
    logic [18:0]          addr;
    logic [7:0]           data;
    int                   n_wr;
    logic [0:5][18:0]     wa;
    logic [0:5][7:0]      wd;
    int                   n_rd;
    logic [18:0]          paddr;
    logic [0:5][7:0]      resp;
    int                   end_cyc;
    bit                   end_err;
    logic [7:0]           rdata;
    int                   ign_cyc;  // cycle to pulse cmd_cerase while busy, 0 = none
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int nb = 0, ai = 0, st = 0, rd_idx = 0;
    int done_cyc = -1, err_cyc = -1, ndone = 0, nerr = 0, nbusy = 0, last_busy = -1;
    int overlap = 0, hib_bad = 0, lim;
    logic [23:0] sh = '0;
    logic [7:0]  end_rdata = 8'h00;
    logic        busy0 = 1'b1;
    int          bst[16];
    logic [18:0] ba[16];
    logic [7:0]  bd[16];
    logic        brd[16];
    lim = v.end_cyc + 20;
    rd_buffer = 8'hEE;
    @(posedge clk);
    #1;
    {cmd_rd, cmd_prog, cmd_serase, cmd_cerase} = v.cmds;
    cmd_addr = v.addr;
    cmd_data = v.data;
    for (int r = 0; r <= lim; r++) begin
      @(negedge clk);
      if (r == 0) busy0 = busy;
      if (r == 1) begin
        {cmd_rd, cmd_prog, cmd_serase, cmd_cerase} = 4'b0000;
        cmd_addr = 19'h0;
        cmd_data = 8'hFF;
      end
      if (v.ign_cyc != 0 && r == v.ign_cyc)     cmd_cerase = 1'b1;
      if (v.ign_cyc != 0 && r == v.ign_cyc + 1) cmd_cerase = 1'b0;
      if (int'(wr_addr) + int'(wr_data) + int'(rd_data) > 1) overlap++;
      if (wr_addr) begin
        if (ai == 0) st = r;
        sh = {wr_buffer, sh[23:8]};
        ai++;
      end
      if (wr_data || rd_data) begin
        if (sh[23:19] != 5'b0) hib_bad++;
        if (nb < 16) begin
          bst[nb] = st; ba[nb] = sh[18:0]; bd[nb] = wr_buffer; brd[nb] = rd_data;
        end
        nb++;
        ai = 0;
        if (rd_data) begin
          rd_buffer = v.resp[rd_idx];
          if (rd_idx < 5) rd_idx++;
        end
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = r; end_rdata = rdata; end
      end
      if (err) begin
        nerr++;
        if (err_cyc < 0) begin err_cyc = r; end_rdata = rdata; end
      end
      if (busy) begin nbusy++; last_busy = r; end
    end
    chk({tag, "_busy_c0"}, 32'(busy0), 32'd0);
    chk({tag, "_bc_count"}, 32'(nb), 32'(v.n_wr + v.n_rd));
    for (int i = 0; i < v.n_wr + v.n_rd && i < nb && i < 16; i++) begin
      chk($sformatf("%s_bc%0d_start", tag, i), 32'(bst[i]), 32'(1 + 12 * i));
      chk($sformatf("%s_bc%0d_rd", tag, i), 32'(brd[i]), 32'(i >= v.n_wr));
      if (i < v.n_wr) begin
        chk($sformatf("%s_bc%0d_addr", tag, i), 32'(ba[i]), 32'(v.wa[i]));
        chk($sformatf("%s_bc%0d_data", tag, i), 32'(bd[i]), 32'(v.wd[i]));
      end else begin
        chk($sformatf("%s_bc%0d_addr", tag, i), 32'(ba[i]), 32'(v.paddr));
      end
    end
    if (v.end_err) begin
      chk({tag, "_err_cyc"}, 32'(err_cyc), 32'(v.end_cyc));
      chk({tag, "_n_err"}, 32'(nerr), 32'd1);
      chk({tag, "_n_done"}, 32'(ndone), 32'd0);
    end else begin
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(v.end_cyc));
      chk({tag, "_n_done"}, 32'(ndone), 32'd1);
      chk({tag, "_n_err"}, 32'(nerr), 32'd0);
    end
    chk({tag, "_rdata"}, 32'(end_rdata), 32'(v.rdata));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(v.end_cyc));
    chk({tag, "_busy_last"}, 32'(last_busy), 32'(v.end_cyc));
    chk({tag, "_strobe_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_addr_hi_bits"}, 32'(hib_bad), 32'd0);
  endtask

  initial begin
    vt[0] = '{4'b1000, 19'h7A5C3, 8'h00, 0, '0, '0, 1, 19'h7A5C3, {8'h5E, 40'h0},
              13, 1'b0, 8'h5E, 0};
    vt[1] = '{4'b0100, 19'h01234, 8'h81, 4,
              {19'h555, 19'h2AA, 19'h555, 19'h01234, 19'h0, 19'h0},
              {8'hAA, 8'h55, 8'hA0, 8'h81, 16'h0}, 4, 19'h01234,
              {8'h01, 8'h01, 8'h01, 8'h81, 16'h0}, 97, 1'b0, 8'h81, 20};
    vt[2] = '{4'b0100, 19'h0ABCD, 8'h80, 4,
              {19'h555, 19'h2AA, 19'h555, 19'h0ABCD, 19'h0, 19'h0},
              {8'hAA, 8'h55, 8'hA0, 8'h80, 16'h0}, 2, 19'h0ABCD,
              {8'h20, 8'h20, 32'h0}, 73, 1'b1, 8'h20, 0};
    vt[3] = '{4'b0010, 19'h5F00F, 8'h00, 6,
              {19'h555, 19'h2AA, 19'h555, 19'h555, 19'h2AA, 19'h5F00F},
              {8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30}, 4, 19'h5F00F,
              48'h0, 121, 1'b1, 8'h00, 0};
    vt[4] = '{4'b1100, 19'h12345, 8'h99, 0, '0, '0, 1, 19'h12345, {8'hA7, 40'h0},
              13, 1'b0, 8'hA7, 0};
    vt[5] = '{4'b0001, 19'h3C3C3, 8'h00, 6,
              {19'h555, 19'h2AA, 19'h555, 19'h555, 19'h2AA, 19'h555},
              {8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h10}, 2, 19'h00000,
              {8'h4C, 8'hFF, 32'h0}, 97, 1'b0, 8'hFF, 0};
    vt[6] = '{4'b0010, 19'h40010, 8'h00, 6,
              {19'h555, 19'h2AA, 19'h555, 19'h555, 19'h2AA, 19'h40010},
              {8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30}, 2, 19'h40010,
              {8'h20, 8'hA0, 32'h0}, 97, 1'b0, 8'hA0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_strobes", 32'({wr_addr, wr_data, rd_data}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_wr_buffer", 32'(wr_buffer), 32'h00);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec($sformatf("v%0d", k), vt[k]);

    // Reset in the middle of a program, while an address strobe is high.
    @(posedge clk);
    #1;
    cmd_prog = 1'b1; cmd_addr = 19'h01234; cmd_data = 8'h81;
    for (int r = 0; r <= 26; r++) begin
      @(negedge clk);
      if (r == 1) cmd_prog = 1'b0;
    end
    chk("mid_wr_addr_before", 32'(wr_addr), 32'd1);
    chk("mid_wr_buffer_before", 32'(wr_buffer), 32'h05);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({wr_addr, wr_data, rd_data}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_rst", vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
